// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM fader.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEADY  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Width needed to address n items, never less than one bit.
  function automatic int unsigned calc_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Configuration valid/ready port: one channel mode/level write per transfer.
interface led_pwm_fader_if #(
  parameter int unsigned CHW       = 2,
  parameter int unsigned PWM_WIDTH = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHW-1:0]       cfg_chan;
  logic [1:0]           cfg_mode;
  logic [PWM_WIDTH-1:0] cfg_level;

  modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_level, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_mode, cfg_level, output cfg_ready);
endinterface

// File: rtl/led_pwm_channel.sv
// One PWM channel: mode/level state, breathe ramp, per-period duty latch and compare flop.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 wrap,
  input  logic                 fade_step,
  input  logic                 blink_on,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 apply,
  input  mode_e                apply_mode,
  input  logic [PWM_WIDTH-1:0] apply_level,
  output logic                 pwm_o
);

  mode_e                mode_q, mode_d;
  logic [PWM_WIDTH-1:0] level_q, level_d;
  logic [PWM_WIDTH-1:0] cur_q, cur_d;
  logic                 dir_q, dir_d;     // 0 = ramping up
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 pwm_q, pwm_d;
  logic [PWM_WIDTH-1:0] eff_c;

  // Next state: apply beats the breathe step; duty is taken from post-update state.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    eff_c   = '0;
    pwm_d   = enable && (pwm_cnt < duty_q);

    if (apply) begin
      mode_d  = apply_mode;
      level_d = apply_level;
      if (apply_mode == MODE_BREATHE) begin
        cur_d = '0;
        dir_d = 1'b0;
      end
    end else if (fade_step && (mode_q == MODE_BREATHE) && (level_q != '0)) begin
      if (!dir_q) begin
        if (cur_q < level_q) begin
          cur_d = cur_q + PWM_WIDTH'(1);
        end else begin
          dir_d = 1'b1;
          cur_d = cur_q - PWM_WIDTH'(1);
        end
      end else begin
        if (cur_q != '0) begin
          cur_d = cur_q - PWM_WIDTH'(1);
        end else begin
          dir_d = 1'b0;
          cur_d = cur_q + PWM_WIDTH'(1);
        end
      end
    end

    case (mode_d)
      MODE_STEADY:  eff_c = level_d;
      MODE_BLINK:   eff_c = blink_on ? level_d : '0;
      MODE_BREATHE: eff_c = cur_d;
      default:      eff_c = '0;
    endcase

    // While disabled the counter sits at a period start, so tracking is glitch-free.
    if (wrap || !enable) duty_d = eff_c;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      level_q <= '0;
      cur_q   <= '0;
      dir_q   <= 1'b0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      level_q <= level_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM generator: prescaler, period counters and config shadow.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned PWM_WIDTH     = 8,
  parameter int unsigned PRESCALE      = 188,
  parameter int unsigned FADE_DIV      = 4,
  parameter int unsigned BLINK_PERIODS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  led_pwm_fader_if.slave      cfg,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_start
);

  localparam int unsigned CHW = calc_w(CHANNELS);
  localparam int unsigned PSW = calc_w(PRESCALE);
  localparam int unsigned FW  = calc_w(FADE_DIV);
  localparam int unsigned BW  = calc_w(BLINK_PERIODS);
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

  logic [PSW-1:0]       presc_q, presc_d;
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [FW-1:0]        fade_q, fade_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 blink_off_q, blink_off_d;
  logic                 ps_q, ps_d;
  logic                 pend_q, pend_d;
  logic [CHW-1:0]       sh_chan_q, sh_chan_d;
  mode_e                sh_mode_q, sh_mode_d;
  logic [PWM_WIDTH-1:0] sh_level_q, sh_level_d;

  logic tick_c, wrap_c, fade_step_c, apply_c, accept_c, chan_ok_c;

  assign tick_c      = enable && (presc_q == PSW'(PRESCALE - 1));
  assign wrap_c      = tick_c && (cnt_q == CNT_MAX);
  assign fade_step_c = wrap_c && (fade_q == FW'(FADE_DIV - 1));
  assign apply_c     = pend_q && (wrap_c || !enable);
  assign accept_c    = cfg.cfg_valid && !pend_q;
  assign chan_ok_c   = 32'(cfg.cfg_chan) < CHANNELS;

  // Timebase, period events and config shadow next-state.
  always_comb begin
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    fade_d      = fade_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    ps_d        = wrap_c;
    pend_d      = pend_q;
    sh_chan_d   = sh_chan_q;
    sh_mode_d   = sh_mode_q;
    sh_level_d  = sh_level_q;

    if (!enable) begin
      presc_d     = '0;
      cnt_d       = '0;
      fade_d      = '0;
      blink_cnt_d = '0;
    end else begin
      presc_d = tick_c ? '0 : presc_q + PSW'(1);
      if (tick_c) cnt_d = cnt_q + PWM_WIDTH'(1);
      if (wrap_c) begin
        fade_d = fade_step_c ? '0 : fade_q + FW'(1);
        if (blink_cnt_q == BW'(BLINK_PERIODS - 1)) begin
          blink_cnt_d = '0;
          blink_off_d = !blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end

    if (apply_c) pend_d = 1'b0;
    if (accept_c && chan_ok_c) begin
      pend_d     = 1'b1;
      sh_chan_d  = cfg.cfg_chan;
      sh_mode_d  = mode_e'(cfg.cfg_mode);
      sh_level_d = cfg.cfg_level;
    end
  end

  // Timebase and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      fade_q      <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      ps_q        <= 1'b0;
      pend_q      <= 1'b0;
      sh_chan_q   <= '0;
      sh_mode_q   <= MODE_OFF;
      sh_level_q  <= '0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      fade_q      <= fade_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      ps_q        <= ps_d;
      pend_q      <= pend_d;
      sh_chan_q   <= sh_chan_d;
      sh_mode_q   <= sh_mode_d;
      sh_level_q  <= sh_level_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign period_start  = ps_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .wrap        (wrap_c),
      .fade_step   (fade_step_c),
      .blink_on    (!blink_off_d),
      .pwm_cnt     (cnt_q),
      .apply       (apply_c && (sh_chan_q == CHW'(c))),
      .apply_mode  (sh_mode_q),
      .apply_level (sh_level_q),
      .pwm_o       (pwm_o[c])
    );
  end

endmodule
